hazard_ctrl_v2: RTL
===================

Name: hazard_ctrl_v2

Overview:
- Second-generation hazard and pipeline-control unit for the 5-stage MIPS core.
- Keeps register forwarding, load-use detection and branch/jr stall detection.
- Adds a parametrised register-address width, configurable exception/ERET targets, and a registered exception-redirect handshake with the fetch stage.
- Adds a multi-cycle divider wait FSM with a watchdog, and per-stage stall/flush outputs for all five stages, including memory-wait freezing.

Parameters:
REG_AW, 5, register address width.
EXC_VECTOR, 32'hBFC00380, redirect target for all non-ERET exceptions.
ERET_CODE, 32'h0000000E, excepttypeM value that denotes ERET.
DIV_TIMEOUT, 64, cycles in DIV_WAIT after which div_timeout is raised.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  reset, synchronous, active-low.
regwriteE, regwriteM, regwriteW  in  1 each  stage writes the register file.
memtoRegE, memtoRegM  in  1 each  stage holds a load.
branchD, jrD  in  1 each  decode holds a branch / jr.
rsD, rtD, rsE, rtE  in  REG_AW each  source register numbers.
reg_waddrE, reg_waddrM, reg_waddrW  in  REG_AW each  destination register numbers.
div_startE  in  1  divide instruction in E.
div_readyE  in  1  divider result valid this cycle.
inst_stall  in  1  fetch memory not ready.
data_stall  in  1  data memory not ready.
excepttypeM  in  32  exception code of the instruction in M; 0 = none.
cp0_epcM  in  32  current EPC.
stallF, stallD, stallE, stallM, stallW  out  1 each  hold the stage register.
flushF, flushD, flushE, flushM, flushW  out  1 each  clear the stage register.
forwardAD, forwardBD  out  1 each  decode forward from M.
forwardAE, forwardBE  out  2 each  10 = from M, 01 = from W, 00 = register file.
pc_redirect  out  1  newpcM is valid; fetch must load it.
newpcM  out  32  redirect target (registered).
div_cancel  out  1  abort the divider.
div_timeout  out  1  sticky watchdog flag.

Behaviour:
- Forwarding (combinational):
  - Register 0 is never forwarded.
  - forwardAE/BE select M first, then W, otherwise 00.
  - forwardAD/BD = source reg != 0 & source == reg_waddrM & regwriteM.
- Hazard terms:
  - lw = memtoRegE & rtE != 0 & (rsD == rtE | rtD == rtE).
  - br = branchD & ((regwriteE & reg_waddrE matches rsD or rtD) | (memtoRegM & reg_waddrM matches rsD or rtD)).
  - jr = same as br, with jrD and rsD only.
- FSM states: RUN, DIV_WAIT, EXC_PEND. Reset → RUN, newpcM = 0, div counter = 0, div_timeout = 0.
- div_busy = (RUN & div_startE & !div_readyE) | DIV_WAIT.
- Transitions:
  - RUN → DIV_WAIT when div_startE & !div_readyE & no exception.
  - DIV_WAIT → RUN when div_readyE.
  - RUN or DIV_WAIT → EXC_PEND when excepttypeM != 0. Exception wins over divider, load-use and memory-wait conditions.
  - EXC_PEND → RUN on the first cycle with inst_stall = 0.
  - excepttypeM is ignored while in EXC_PEND.
- Stall/flush in RUN and DIV_WAIT, no exception:
  - stallF = stallD = lw | br | jr | div_busy | inst_stall | data_stall.
  - stallE = div_busy | data_stall.
  - stallM = stallW = data_stall.
  - flushE = (lw | br | jr) & !div_busy & !data_stall.
  - flushM = div_busy & !data_stall (bubble behind the divider).
  - flushF = flushD = flushW = 0.
- Exception-detect cycle:
  - flushF..flushW = 1; all stalls = 0; div_cancel = 1 if div_busy.
  - newpcM is loaded at the edge: cp0_epcM if excepttypeM == ERET_CODE, else EXC_VECTOR (every other nonzero code).
- In EXC_PEND:
  - pc_redirect = 1; flushD..flushW = 1; stallF = 0.
  - newpcM holds its value; redirect latency is 1 cycle after detection.
- Divider counter: clears on entry to DIV_WAIT and increments each cycle in DIV_WAIT, saturating.
- div_timeout sets when the counter reaches DIV_TIMEOUT and clears only on reset.
- resetn low mid-operation: the next edge returns the FSM to RUN; pc_redirect deasserts that cycle.

Test Plan:
- Forwarding: rsE = 3, reg_waddrM = 3, regwriteM = 1, reg_waddrW = 3, regwriteW = 1 → forwardAE = 10. Same with rsE = 0 → forwardAE = 00.
- Load-use: memtoRegE = 1, rtE = 8, rsD = 8 → stallF = stallD = flushE = 1 for one cycle. With rtE = 0 → no stall.
- Divide: div_startE = 1, div_readyE low for 5 cycles, then high → stallF/D/E and flushM held 6 cycles total; FSM returns to RUN.
- Exception during divide: excepttypeM = 32'h8 in DIV_WAIT → all flushes and div_cancel = 1. Next cycle: pc_redirect = 1, newpcM = 32'hBFC00380.
- ERET with inst_stall: excepttypeM = 32'hE, cp0_epcM = 32'h80001000, inst_stall high 3 cycles → pc_redirect held 3 cycles, newpcM = 32'h80001000, then RUN.
- Watchdog: DIV_TIMEOUT = 4, div_readyE never asserted → div_timeout rises after 4 cycles in DIV_WAIT and stays high until resetn = 0.

Source files
------------

// File: rtl/hazard_ctrl_v2.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: forwarding, load-use/branch stalls,
// divider wait with watchdog, and a registered exception-redirect handshake with fetch.
module hazard_ctrl_v2 #(
   parameter int          REG_AW      = 5,
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
   parameter logic [31:0] ERET_CODE   = 32'h0000000E,
   parameter int          DIV_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              regwriteE,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic              memtoRegE,
   input  logic              memtoRegM,
   input  logic              branchD,
   input  logic              jrD,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] reg_waddrE,
   input  logic [REG_AW-1:0] reg_waddrM,
   input  logic [REG_AW-1:0] reg_waddrW,
   input  logic              div_startE,
   input  logic              div_readyE,
   input  logic              inst_stall,
   input  logic              data_stall,
   input  logic [31:0]       excepttypeM,
   input  logic [31:0]       cp0_epcM,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              stallW,
   output logic              flushF,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW,
   output logic              forwardAD,
   output logic              forwardBD,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE,
   output logic              pc_redirect,
   output logic [31:0]       newpcM,
   output logic              div_cancel,
   output logic              div_timeout
);

   localparam int CW = (DIV_TIMEOUT < 1) ? 1 : $clog2(DIV_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(DIV_TIMEOUT);

   typedef enum logic [1:0] {RUN, DIV_WAIT, EXC_PEND} state_t;

   state_t          state_reg;
   logic [31:0]     newpc_reg;
   logic [CW-1:0]   cnt_reg;
   logic [CW-1:0]   cnt_inc;
   logic            timeout_reg;
   logic            redirect_reg;

   logic [REG_AW-1:0] src_e [2];
   logic [REG_AW-1:0] src_d [2];
   logic [1:0]        fwd_e [2];
   logic              fwd_d [2];

   logic        lw_hz, br_hz, jr_hz, any_hz;
   logic        exc_take, div_busy;
   logic [31:0] exc_target;

   assign src_e[0] = rsE;
   assign src_e[1] = rtE;
   assign src_d[0] = rsD;
   assign src_d[1] = rtD;

   // Operand A uses index 0, operand B index 1; M has priority over W, r0 never forwards.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_e[gi] = (src_e[gi] != '0 && regwriteM && src_e[gi] == reg_waddrM) ? 2'b10 :
                            (src_e[gi] != '0 && regwriteW && src_e[gi] == reg_waddrW) ? 2'b01 : 2'b00;
         assign fwd_d[gi] = (src_d[gi] != '0) && regwriteM && (src_d[gi] == reg_waddrM);
      end
   endgenerate

   assign forwardAE = fwd_e[0];
   assign forwardBE = fwd_e[1];
   assign forwardAD = fwd_d[0];
   assign forwardBD = fwd_d[1];

   assign lw_hz  = memtoRegE && (rtE != '0) && (rsD == rtE || rtD == rtE);
   assign br_hz  = branchD && ((regwriteE && (reg_waddrE == rsD || reg_waddrE == rtD)) ||
                               (memtoRegM && (reg_waddrM == rsD || reg_waddrM == rtD)));
   assign jr_hz  = jrD && ((regwriteE && reg_waddrE == rsD) || (memtoRegM && reg_waddrM == rsD));
   assign any_hz = lw_hz || br_hz || jr_hz;

   assign exc_take   = (state_reg != EXC_PEND) && (excepttypeM != 32'd0);
   assign div_busy   = (state_reg == RUN && div_startE && !div_readyE) || (state_reg == DIV_WAIT);
   assign exc_target = (excepttypeM == ERET_CODE) ? cp0_epcM : EXC_VECTOR;
   assign cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + CW'(1);

   always_comb begin
      stallF     = 1'b0;
      stallD     = 1'b0;
      stallE     = 1'b0;
      stallM     = 1'b0;
      stallW     = 1'b0;
      flushF     = 1'b0;
      flushD     = 1'b0;
      flushE     = 1'b0;
      flushM     = 1'b0;
      flushW     = 1'b0;
      div_cancel = 1'b0;
      if (exc_take) begin
         {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
         div_cancel = div_busy;
      end else if (state_reg == EXC_PEND) begin
         {flushD, flushE, flushM, flushW} = 4'b1111;
      end else begin
         stallF = any_hz || div_busy || inst_stall || data_stall;
         stallD = stallF;
         stallE = div_busy || data_stall;
         stallM = data_stall;
         stallW = data_stall;
         flushE = any_hz && !div_busy && !data_stall;
         // Insert a bubble into M while E is held by the divider.
         flushM = div_busy && !data_stall;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= RUN;
         newpc_reg    <= 32'd0;
         cnt_reg      <= '0;
         timeout_reg  <= 1'b0;
         redirect_reg <= 1'b0;
      end else begin
         if (state_reg == DIV_WAIT) begin
            cnt_reg <= cnt_inc;
            if (cnt_inc >= TIMEOUT_VAL) timeout_reg <= 1'b1;
         end
         case (state_reg)
            RUN: begin
               if (exc_take) begin
                  state_reg    <= EXC_PEND;
                  newpc_reg    <= exc_target;
                  redirect_reg <= 1'b1;
               end else if (div_startE && !div_readyE) begin
                  state_reg <= DIV_WAIT;
                  cnt_reg   <= '0;
               end
            end
            DIV_WAIT: begin
               if (exc_take) begin
                  state_reg    <= EXC_PEND;
                  newpc_reg    <= exc_target;
                  redirect_reg <= 1'b1;
               end else if (div_readyE) begin
                  state_reg <= RUN;
               end
            end
            EXC_PEND: begin
               // Fetch accepts the redirect once its memory is ready.
               if (!inst_stall) begin
                  state_reg    <= RUN;
                  redirect_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= RUN;
               redirect_reg <= 1'b0;
            end
         endcase
      end
   end

   assign pc_redirect = redirect_reg;
   assign newpcM      = newpc_reg;
   assign div_timeout = timeout_reg;

endmodule
